// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_pkg
// Description : Shared AXI4-Stream definitions: error-flag bit positions and
//               the TKEEP/TSTRB width helper used by the transmitter, the
//               receiver and the monitor.
// Contents    : AXIS_ERR_* bit indices into err_flags, AXIS_ERR_W,
//               keep_width(tdata_w)
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  localparam int AXIS_ERR_VALID_DROP = 0;
  localparam int AXIS_ERR_UNSTABLE   = 1;
  localparam int AXIS_ERR_KEEP_STRB  = 2;
  localparam int AXIS_ERR_W          = 3;

  // One TKEEP/TSTRB bit per TDATA byte.
  function automatic int keep_width(input int tdata_w);
    return tdata_w / 8;
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Interface   : axis_if
// Description : AXI4-Stream channel bundle between one transmitter and one
//               receiver.
// Modports    : master - drives TVALID and the payload, samples TREADY
//               slave  - samples TVALID and the payload, drives TREADY
// Signals     : TVALID, TREADY, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_if
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 1
);

  localparam int KW = keep_width(TDATA_WIDTH);

  logic                   TVALID;
  logic                   TREADY;
  logic [TDATA_WIDTH-1:0] TDATA;
  logic [KW-1:0]          TKEEP;
  logic [KW-1:0]          TSTRB;
  logic                   TLAST;
  logic [TID_WIDTH-1:0]   TID;
  logic [TDEST_WIDTH-1:0] TDEST;
  logic [TUSER_WIDTH-1:0] TUSER;

  modport master (
    output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
    output TREADY
  );

endinterface : axis_if
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_sync_fifo
// Description : Generic first-word-fall-through synchronous FIFO. The head
//               entry is always visible on dout while the FIFO is not empty.
// Ports       : clk, rst      - clock, synchronous active-high reset (flush)
//               push, din     - write request and data (ignored when full)
//               pop           - remove head entry (ignored when empty)
//               dout          - head entry
//               full, empty   - occupancy flags
//               level         - number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         din,
  input  wire logic                     pop,
  output      logic [WIDTH-1:0]         dout,
  output      logic                     full,
  output      logic                     empty,
  output      logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; a flush only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule : axis_sync_fifo
`default_nettype wire

// File: rtl/axis_receiver.sv
`default_nettype none
// ============================================================================
// Module      : axis_receiver
// Description : AXI4-Stream slave. Accepts beats into an FWFT buffer, presents
//               them on a valid/ready consumer port, throttles TREADY with a
//               rotating mask, checks transmitter protocol rules and counts
//               completed frames.
// Ports       : ACLK, ARESET          - clock, synchronous active-high reset
//               s_axis (axis_if.slave)- incoming stream
//               out_valid/out_ready   - consumer handshake
//               out_data..out_user    - head beat fields
//               thr_en, thr_pattern   - TREADY throttling enable and mask
//               err_clr, err_flags    - sticky protocol errors and clear
//               frame_count           - accepted TLAST beats (wrapping)
//               fifo_level            - buffered beats
// Revision    : 1.0 - initial release
// ============================================================================
module axis_receiver
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 16,
  localparam int KW         = keep_width(TDATA_WIDTH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic                   ACLK,
  input  wire logic                   ARESET,
  axis_if.slave                       s_axis,
  output      logic                   out_valid,
  input  wire logic                   out_ready,
  output      logic [TDATA_WIDTH-1:0] out_data,
  output      logic [KW-1:0]          out_keep,
  output      logic [KW-1:0]          out_strb,
  output      logic                   out_last,
  output      logic [TID_WIDTH-1:0]   out_id,
  output      logic [TDEST_WIDTH-1:0] out_dest,
  output      logic [TUSER_WIDTH-1:0] out_user,
  input  wire logic                   thr_en,
  input  wire logic [7:0]             thr_pattern,
  input  wire logic                   err_clr,
  output      logic [AXIS_ERR_W-1:0]  err_flags,
  output      logic [31:0]            frame_count,
  output      logic [LVL_W-1:0]       fifo_level
);

  localparam int ENTRY_W = TDATA_WIDTH + 2*KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  logic [ENTRY_W-1:0]    w_beat;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_pop;
  logic [AXIS_ERR_W-1:0] w_err_set;

  logic [2:0]            r_idx;
  logic                  r_stalled;
  logic [ENTRY_W-1:0]    r_stall_beat;
  logic [AXIS_ERR_W-1:0] r_err;
  logic [31:0]           r_frame_count;

  assign w_beat = {s_axis.TDATA, s_axis.TKEEP, s_axis.TSTRB, s_axis.TLAST,
                   s_axis.TID, s_axis.TDEST, s_axis.TUSER};

  // TREADY never looks at TVALID, so the transmitter cannot form a loop.
  assign w_tready      = !ARESET && !w_full && (!thr_en || thr_pattern[r_idx]);
  assign s_axis.TREADY = w_tready;
  assign w_accept      = s_axis.TVALID && w_tready;

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign {out_data, out_keep, out_strb, out_last, out_id, out_dest, out_user} = w_head;

  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (w_accept),
    .din   (w_beat),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // Throttle mask index: runs only while throttling, parked at bit 0 otherwise.
  always_ff @(posedge ACLK) begin
    if (ARESET)      r_idx <= 3'd0;
    else if (thr_en) r_idx <= r_idx + 3'd1;
    else             r_idx <= 3'd0;
  end

  // Remember a refused beat so the next cycle can verify it was held.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_stalled    <= 1'b0;
      r_stall_beat <= '0;
    end else begin
      r_stalled <= s_axis.TVALID && !w_tready;
      if (s_axis.TVALID && !w_tready) r_stall_beat <= w_beat;
    end
  end

  always_comb begin
    w_err_set                      = '0;
    w_err_set[AXIS_ERR_VALID_DROP] = r_stalled && !s_axis.TVALID;
    w_err_set[AXIS_ERR_UNSTABLE]   = r_stalled && s_axis.TVALID && (w_beat != r_stall_beat);
    w_err_set[AXIS_ERR_KEEP_STRB]  = w_accept && (|(s_axis.TSTRB & ~s_axis.TKEEP));
  end

  // A new error in the same cycle as a clear survives the clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_err <= '0;
    else        r_err <= (err_clr ? '0 : r_err) | w_err_set;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)                        r_frame_count <= 32'd0;
    else if (w_accept && s_axis.TLAST) r_frame_count <= r_frame_count + 32'd1;
  end

  assign err_flags   = r_err;
  assign frame_count = r_frame_count;

endmodule : axis_receiver
`default_nettype wire
